// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the imem boot loader.
package imem_boot_loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StCsum,
    StDone,
    StErr
  } loader_state_e;

  // Canonical NOP (addi x0, x0, 0), shared with imem.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Bytes per header / per data word.
  localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects a little-endian byte stream into 32-bit words.
// word_valid_o is combinational: it fires on the 4th byte of each word so the
// consumer can register the word on the same edge the byte is accepted.
module byte_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam int unsigned CntW = $clog2(HDR_BYTES);
  localparam logic [CntW-1:0] LastByte = CntW'(HDR_BYTES - 1);

  logic [CntW-1:0] cnt_q;
  logic [23:0]     shreg_q;

  // Byte counter and shift register; the newest byte enters at the top.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (byte_valid_i) begin
      cnt_q   <= cnt_q + CntW'(1);
      shreg_q <= {byte_i, shreg_q[23:8]};
    end
  end

  assign word_valid_o = byte_valid_i && (cnt_q == LastByte);
  assign word_o       = {byte_i, shreg_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed image into imem and holds the CPU in
// reset until a complete, valid image has been written.
// Optional checksum stage enabled by defining IMEM_BOOT_LOADER_CSUM_EN.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_PC     = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           rx_valid_i,
  output logic                           rx_ready_o,
  input  logic [7:0]                     rx_data_i,
  output logic                           imem_we_o,
  output logic [$clog2(DEPTH_WORDS)-1:0] imem_waddr_o,
  output logic [31:0]                    imem_wdata_o,
  output logic                           cpu_rst_no,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
  typedef logic [AddrW:0] cnt_t;

  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of two and at least 2");
  end
  if (BASE_PC[1:0] != 2'b00) begin : g_bad_base
    $error("BASE_PC must be word aligned");
  end

  loader_state_e    state_q;
  cnt_t             word_cnt_q;
  cnt_t             n_q;
  logic             imem_we_q;
  logic [AddrW-1:0] waddr_q;
  logic [31:0]      wdata_q;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
  logic [31:0]      csum_q;
`endif

  logic        busy;
  logic        start_ok;
  logic        byte_ok;
  logic        word_valid;
  logic [31:0] word;

  assign busy     = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
  assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign byte_ok  = rx_valid_i && busy;

  byte_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (start_ok),
    .byte_valid_i (byte_ok),
    .byte_i       (rx_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Loader FSM with registered imem write port.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      n_q        <= '0;
      imem_we_q  <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        StIdle, StDone, StErr: begin
          if (start_i) begin
            state_q    <= StHdr;
            word_cnt_q <= '0;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        StHdr: begin
          if (word_valid) begin
            if (word == 32'd0 || word > 32'(DEPTH_WORDS)) begin
              state_q <= StErr;
            end else begin
              n_q     <= word[AddrW:0];
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (word_valid) begin
            imem_we_q  <= 1'b1;
            waddr_q    <= word_cnt_q[AddrW-1:0];
            wdata_q    <= word;
            word_cnt_q <= word_cnt_q + cnt_t'(1);
`ifdef IMEM_BOOT_LOADER_CSUM_EN
            csum_q     <= csum_q ^ word;
            if (word_cnt_q == n_q - cnt_t'(1)) state_q <= StCsum;
`else
            if (word_cnt_q == n_q - cnt_t'(1)) state_q <= StDone;
`endif
          end
        end
`ifdef IMEM_BOOT_LOADER_CSUM_EN
        StCsum: begin
          if (word_valid) state_q <= (word == csum_q) ? StDone : StErr;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_ready_o   = busy;
  assign busy_o       = busy;
  assign done_o       = (state_q == StDone);
  assign err_o        = (state_q == StErr);
  assign cpu_rst_no   = (state_q == StDone);
  assign imem_we_o    = imem_we_q;
  assign imem_waddr_o = waddr_q;
  assign imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader. Expected results come
// from the image itself: word k lands at index k, length rules decide ERR.
module tb_imem_boot_loader;

  localparam int unsigned Depth = 16;
  localparam int unsigned Aw    = $clog2(Depth);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          imem_we;
  logic [Aw-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  imem_boot_loader #(
    .BASE_PC     (32'h0000_0000),
    .DEPTH_WORDS (Depth)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready),
    .rx_data_i    (rx_data),
    .imem_we_o    (imem_we),
    .imem_waddr_o (imem_waddr),
    .imem_wdata_o (imem_wdata),
    .cpu_rst_no   (cpu_rst_n),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem [Depth];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] img_words[$];
  logic [31:0] img_csum;

  // imem stand-in: records every write the DUT issues.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(int'(imem_waddr));
      wr_data_q.push_back(imem_wdata);
      mem[imem_waddr] = imem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one byte from a negedge until it is accepted; returns on a negedge.
  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int tries = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!acc && tries < 50) begin
      acc = rx_ready;
      @(negedge clk);
      tries++;
    end
    if (!acc) check_eq("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("cpu_rst_after_start", 32'(cpu_rst_n), 32'd0);
    check_eq("done_after_start", 32'(done), 32'd0);
  endtask

  task automatic run_load(input logic [31:0] n, input bit throttle, input bit mid_start);
    logic [7:0]  bytes[$];
    logic [31:0] xr;
    bit          bad;
    bit          ok;
    int          n_exp;
    bad = (n == 0) || (n > Depth);
    for (int i = 0; i < 4; i++) bytes.push_back(n[8*i +: 8]);
    if (!bad) begin
      foreach (img_words[k]) for (int j = 0; j < 4; j++) bytes.push_back(img_words[k][8*j +: 8]);
`ifdef IMEM_BOOT_LOADER_CSUM_EN
      for (int j = 0; j < 4; j++) bytes.push_back(img_csum[8*j +: 8]);
`endif
    end
    xr = '0;
    foreach (img_words[k]) xr ^= img_words[k];
    ok = !bad;
`ifdef IMEM_BOOT_LOADER_CSUM_EN
    ok = ok && (img_csum == xr);
`endif
    n_exp = bad ? 0 : int'(n);
    wr_addr_q.delete();
    wr_data_q.delete();
    do_start();
    foreach (bytes[i]) begin
      if (mid_start && i == 6) start = 1'b1;
      send_byte(bytes[i]);
      start = 1'b0;
      if (throttle && i < bytes.size() - 1) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    rx_valid = 1'b0;
    check_eq("done", 32'(done), 32'(ok));
    check_eq("err", 32'(err), 32'(!ok));
    check_eq("cpu_rst_n", 32'(cpu_rst_n), 32'(ok));
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("rx_ready_end", 32'(rx_ready), 32'd0);
`ifndef IMEM_BOOT_LOADER_CSUM_EN
    if (!bad) begin
      check_eq("last_we_with_done", 32'(imem_we), 32'd1);
      check_eq("last_waddr", 32'(imem_waddr), n - 32'd1);
      check_eq("last_wdata", imem_wdata, img_words[n-1]);
    end
`endif
    #1;
    check_eq("write_count", 32'(wr_addr_q.size()), 32'(n_exp));
    for (int k = 0; k < wr_addr_q.size() && k < n_exp; k++) begin
      check_eq("write_addr", 32'(wr_addr_q[k]), 32'(k));
      check_eq("write_data", wr_data_q[k], img_words[k]);
    end
    repeat (2) @(negedge clk);
    check_eq("state_hold", {30'd0, done, err}, {30'd0, ok, !ok});
  endtask

  task automatic rand_image(input int n);
    img_words.delete();
    img_csum = '0;
    for (int k = 0; k < n; k++) begin
      img_words.push_back($urandom);
      img_csum ^= img_words[k];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check_eq({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check_eq({tag, "_imem_waddr"}, 32'(imem_waddr), 32'd0);
    check_eq({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check_eq({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Bytes offered while idle must not be consumed.
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (3) @(negedge clk);
    check_eq("idle_rx_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;

    // Normal load.
    img_words = '{32'h1111_1111, 32'h2222_2222};
    img_csum  = 32'h3333_3333;
    run_load(32'd2, 1'b0, 1'b0);
    check_eq("imem_pc0", mem[32'h0 >> 2], 32'h1111_1111);
    check_eq("imem_pc4", mem[32'h4 >> 2], 32'h2222_2222);

    // Bad lengths.
    run_load(Depth + 1, 1'b0, 1'b0);
    run_load(32'd0, 1'b0, 1'b0);

    // Full-depth image.
    rand_image(Depth);
    run_load(Depth, 1'b0, 1'b0);

    // Throttled stream with an ignored start mid-load.
    img_words = '{32'h1111_1111, 32'h2222_2222};
    img_csum  = 32'h3333_3333;
    run_load(32'd2, 1'b1, 1'b1);

    // Reset after 6 bytes, then a fresh load.
    do_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'hA5);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check_reset_outputs("midload_reset");
    rst_n = 1'b1;
    rand_image(3);
    run_load(32'd3, 1'b0, 1'b0);

`ifdef IMEM_BOOT_LOADER_CSUM_EN
    img_words = '{32'h1111_1111, 32'h2222_2222};
    img_csum  = 32'h3333_3334;
    run_load(32'd2, 1'b0, 1'b0);
`endif

    // Randomized images, gaps and lengths.
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(Depth, 1);
      rand_image(n);
`ifdef IMEM_BOOT_LOADER_CSUM_EN
      if ($urandom_range(3, 0) == 0) img_csum ^= 32'(1) << $urandom_range(31, 0);
`endif
      run_load(32'(n), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    for (int it = 0; it < 3; it++) begin
      logic [31:0] bad_n;
      bad_n = $urandom_range(32'hFFFF, Depth + 1);
      run_load(bad_n, 1'($urandom_range(1, 0)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
